// File: rtl/synth_pkg.sv
// Shared types and constants for the synth's measurement blocks.
// Holds the period meter FSM encoding and clock rate for software.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } pm_state_t;

  localparam int PM_W   = 16;
  localparam int CLK_HZ = 50_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a history flop and rising-edge strobe.
// Reusable for any slow asynchronous input (tone, buttons, encoder).
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign q    = r_s2;
  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/period_meter.sv
// Counts clk cycles between accepted rising edges of an async tone.
// Rejects edges closer than MIN_PERIOD, flags loss of signal at TIMEOUT.
module period_meter
  import synth_pkg::*;
#(
  parameter int W          = PM_W,
  parameter int MIN_PERIOD = 2,
  parameter int TIMEOUT    = (1 << W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tone_in,
  output logic [W-1:0] period_out,
  output logic         period_valid,
  output logic         no_signal,
  output logic         glitch
);

  localparam logic [W-1:0] LP_TO  = W'(TIMEOUT);
  localparam logic [W:0]   LP_MIN = (W+1)'(MIN_PERIOD);

  pm_state_t    r_state;
  pm_state_t    w_state_nxt;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] w_cnt_inc;
  logic [W:0]   w_cnt_p1;
  logic [W-1:0] w_period;
  logic [W-1:0] r_period;
  logic         r_valid;
  logic         r_glitch;
  logic         w_valid_nxt;
  logic         w_glitch_nxt;
  logic         w_load;
  logic         w_rise;
  logic         w_sync;
  logic         w_ok;
  logic         w_at_to;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tone_in),
    .q     (w_sync),
    .rise  (w_rise)
  );

  assign w_cnt_p1  = {1'b0, r_cnt} + (W+1)'(1);
  assign w_ok      = (w_cnt_p1 >= LP_MIN);
  assign w_at_to   = (r_cnt == LP_TO);
  assign w_cnt_inc = w_at_to ? r_cnt : r_cnt + W'(1);
  // An edge accepted exactly at the 2^W-1 saturation point clamps.
  assign w_period  = w_cnt_p1[W] ? {W{1'b1}} : w_cnt_p1[W-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = w_cnt_inc;
    w_valid_nxt  = 1'b0;
    w_glitch_nxt = 1'b0;
    w_load       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = ARM;
        end
      end
      ARM, MEASURE: begin
        if (w_rise && w_ok) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
        end else if (w_rise) begin
          w_glitch_nxt = 1'b1;
        end else if (w_at_to) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_valid  <= w_valid_nxt;
      r_glitch <= w_glitch_nxt;
      if (w_load) begin
        r_period <= w_period;
      end
    end
  end

  // Signal is lost the moment the counter saturates, not a cycle later.
  assign no_signal    = (r_state != MEASURE) | w_at_to | (w_sync & 1'b0);
  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign glitch       = r_glitch;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: three parameterizations against an
// edge-timing reference model, plus vector table and corner sequences.
module tb_period_meter;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] tone;
  logic [15:0]  po0;
  logic [15:0]  po1;
  logic [7:0]   po2;
  logic [N-1:0] pv;
  logic [N-1:0] gl;
  logic [N-1:0] ns;

  period_meter #(.W(16), .MIN_PERIOD(2)) u0 (
    .clk(clk), .rst_n(rst_n), .tone_in(tone[0]), .period_out(po0),
    .period_valid(pv[0]), .no_signal(ns[0]), .glitch(gl[0])
  );
  period_meter #(.W(16), .MIN_PERIOD(4)) u1 (
    .clk(clk), .rst_n(rst_n), .tone_in(tone[1]), .period_out(po1),
    .period_valid(pv[1]), .no_signal(ns[1]), .glitch(gl[1])
  );
  period_meter #(.W(8), .MIN_PERIOD(2), .TIMEOUT(255)) u2 (
    .clk(clk), .rst_n(rst_n), .tone_in(tone[2]), .period_out(po2),
    .period_valid(pv[2]), .no_signal(ns[2]), .glitch(gl[2])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on sampled tone values and times between
  // accepted rising edges, seen two cycles after the sample.
  int minp[N] = '{2, 4, 2};
  int tout[N] = '{65535, 65535, 255};
  int pmax[N] = '{65535, 65535, 255};
  int cyc = 0;
  int mst[N];
  int last[N];
  int smp1[N];
  int smp2[N];
  int smp3[N];
  int exp_p[N];
  int exp_v[N];
  int exp_g[N];
  int exp_ns[N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mst[i] = 0; last[i] = 0;
        smp1[i] = 0; smp2[i] = 0; smp3[i] = 0;
        exp_p[i] = 0; exp_v[i] = 0; exp_g[i] = 0; exp_ns[i] = 1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        int d;
        bit rs;
        rs = (smp2[i] == 1) && (smp3[i] == 0);
        d = cyc - last[i];
        exp_v[i] = 0;
        exp_g[i] = 0;
        if (rs) begin
          if (mst[i] == 0) begin
            mst[i] = 1; last[i] = cyc;
          end else if (d >= minp[i]) begin
            exp_p[i] = (d > pmax[i]) ? pmax[i] : d;
            exp_v[i] = 1; mst[i] = 2; last[i] = cyc;
          end else begin
            exp_g[i] = 1;
          end
        end else if (mst[i] != 0 && d > tout[i]) begin
          mst[i] = 0;
        end
        d = cyc - last[i];
        exp_ns[i] = (mst[i] != 2 || d >= tout[i]) ? 1 : 0;
        smp3[i] = smp2[i]; smp2[i] = smp1[i]; smp1[i] = int'(tone[i]);
      end
    end
  end

  bit run_chk = 0;
  int negcyc = 0;
  int vcnt[N] = '{0, 0, 0};
  int gcnt[N] = '{0, 0, 0};
  int last_v[N] = '{0, 0, 0};

  always @(negedge clk) begin
    int ap[N];
    negcyc++;
    ap = '{int'(po0), int'(po1), int'(po2)};
    for (int i = 0; i < N; i++) begin
      if (pv[i]) begin vcnt[i]++; last_v[i] = negcyc; end
      if (gl[i]) gcnt[i]++;
      if (rst_n && run_chk) begin
        chk($sformatf("u%0d period_out", i), ap[i], exp_p[i]);
        chk($sformatf("u%0d period_valid", i), int'(pv[i]), exp_v[i]);
        chk($sformatf("u%0d glitch", i), int'(gl[i]), exp_g[i]);
        chk($sformatf("u%0d no_signal", i), int'(ns[i]), exp_ns[i]);
      end
    end
  end

  task automatic tone_run(int i, int hi, int lo, int reps);
    for (int r = 0; r < reps; r++) begin
      tone[i] = 1'b1;
      repeat (hi) @(negedge clk);
      tone[i] = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic pad();
    repeat (3) @(negedge clk);
    #1;
  endtask

  typedef struct {
    int inst;
    int hi;
    int lo;
    int reps;
    int exp_p;
    int exp_nv;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int v0;
    int g0;
    int t;
    int aps[N];
    tbl = '{
      '{0, 5, 5, 5, 10, 4},
      '{0, 1, 1, 8, 2, 8},
      '{0, 3, 4, 5, 7, 5},
      '{0, 201, 201, 5, 402, 5},
      '{0, 26, 26, 5, 52, 5},
      '{1, 10, 10, 4, 20, 3},
      '{2, 15, 15, 4, 30, 3}
    };
    rst_n = 1'b0;
    tone = '0;
    repeat (3) @(negedge clk);
    chk("reset period_out u0", int'(po0), 0);
    chk("reset period_out u2", int'(po2), 0);
    chk("reset no_signal", int'(ns), 7);
    chk("reset period_valid", int'(pv), 0);
    chk("reset glitch", int'(gl), 0);
    #2 rst_n = 1'b1;
    run_chk = 1;

    for (int k = 0; k < 7; k++) begin
      v0 = vcnt[tbl[k].inst];
      tone_run(tbl[k].inst, tbl[k].hi, tbl[k].lo, tbl[k].reps);
      pad();
      aps = '{int'(po0), int'(po1), int'(po2)};
      chk($sformatf("vec%0d period", k), aps[tbl[k].inst], tbl[k].exp_p);
      chk($sformatf("vec%0d no_signal", k), int'(ns[tbl[k].inst]), 0);
      chk($sformatf("vec%0d valid count", k), vcnt[tbl[k].inst] - v0,
          tbl[k].exp_nv);
    end

    // Extra short pulse two cycles after a rise on the MIN_PERIOD=4 unit.
    g0 = gcnt[1];
    v0 = vcnt[1];
    tone[1] = 1'b1; @(negedge clk);
    tone[1] = 1'b0; @(negedge clk);
    tone[1] = 1'b1; repeat (8) @(negedge clk);
    tone[1] = 1'b0; repeat (10) @(negedge clk);
    tone_run(1, 10, 10, 2);
    pad();
    chk("glitch count", gcnt[1] - g0, 1);
    chk("glitch valid count", vcnt[1] - v0, 3);
    chk("glitch period", int'(po1), 20);

    // Timeout after the tone stops on the W=8 unit.
    tone_run(2, 15, 15, 2);
    t = 0;
    while (!ns[2] && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    chk("timeout reached", int'(ns[2]), 1);
    chk("timeout distance", negcyc - last_v[2], 255);
    chk("timeout holds period", int'(po2), 30);
    tone_run(2, 15, 15, 3);
    pad();
    chk("restart period", int'(po2), 30);
    chk("restart no_signal", int'(ns[2]), 0);
    tone_run(2, 1, 254, 3);
    pad();
    chk("period 255", int'(po2), 255);
    tone_run(2, 1, 255, 3);
    pad();
    chk("boundary clamp", int'(po2), 255);

    // Reset in the middle of a steady tone.
    fork
      tone_run(0, 5, 5, 10);
      begin
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset period_out", int'(po0), 0);
        chk("midreset no_signal", int'(ns), 7);
        chk("midreset valid", int'(pv), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    join
    pad();
    chk("after reset period", int'(po0), 10);

    // Randomized segments on all three units.
    for (int s = 0; s < 40; s++) begin
      int u;
      u = int'($urandom_range(0, N - 1));
      tone_run(u, int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
               int'($urandom_range(1, 4)));
    end
    pad();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
